// File: rtl/ram_march_bist.sv
// March C- built-in self-test initiator for a single-port DFFRAM macro.
// Drives EN/WE/A/Di, checks Do one cycle after each read, latches the first miscompare.
module ram_march_bist #(
    parameter int              AW  = 13,
    parameter int              DW  = 32,
    parameter logic [DW-1:0]   DBG = {DW{1'b0}}
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic              FAIL,
    output logic [AW-1:0]     FAIL_ADDR,
    output logic [DW-1:0]     FAIL_DATA,
    output logic [2:0]        FAIL_ELEM,
    output logic              RAM_EN,
    output logic [DW/8-1:0]   RAM_WE,
    output logic [AW-1:0]     RAM_A,
    output logic [DW-1:0]     RAM_Di,
    input  logic [DW-1:0]     RAM_Do
);

    localparam int BW = DW / 8;

    localparam logic [3:0] ST_M0    = 4'd0;
    localparam logic [3:0] ST_M1    = 4'd1;
    localparam logic [3:0] ST_M2    = 4'd2;
    localparam logic [3:0] ST_M3    = 4'd3;
    localparam logic [3:0] ST_M4    = 4'd4;
    localparam logic [3:0] ST_M5    = 4'd5;
    localparam logic [3:0] ST_DRAIN = 4'd6;
    localparam logic [3:0] ST_IDLE  = 4'd7;
    localparam logic [3:0] ST_DONE  = 4'd8;

    localparam logic [AW-1:0] A_MAX = {AW{1'b1}};
    localparam logic [AW-1:0] A_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] D0    = DBG;
    localparam logic [DW-1:0] D1    = ~DBG;

    logic [3:0]    state_q, state_d;
    logic          wr_ph_q, wr_ph_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          fail_q, fail_d;
    logic [AW-1:0] fail_addr_q, fail_addr_d;
    logic [DW-1:0] fail_data_q, fail_data_d;
    logic [2:0]    fail_elem_q, fail_elem_d;
    logic          en_q, en_d;
    logic          we_q, we_d;
    logic [AW-1:0] a_q, a_d;
    logic [DW-1:0] di_q, di_d;
    logic          chk_q, chk_d;
    logic [DW-1:0] chk_exp_q, chk_exp_d;
    logic [AW-1:0] chk_addr_q, chk_addr_d;
    logic [2:0]    chk_elem_q, chk_elem_d;

    logic desc;
    logic last;
    logic mis;

    assign desc = (state_q == ST_M3) || (state_q == ST_M4);
    assign last = desc ? (a_q == '0) : (a_q == A_MAX);
    assign mis  = chk_q && (RAM_Do != chk_exp_q);

    always_comb begin
        state_d     = state_q;
        wr_ph_d     = wr_ph_q;
        busy_d      = busy_q;
        done_d      = done_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        fail_elem_d = fail_elem_q;
        en_d        = 1'b0;
        we_d        = 1'b0;
        a_d         = a_q;
        di_d        = di_q;
        chk_d       = 1'b0;
        // Expected read data travels with the read into the compare cycle
        chk_exp_d   = (state_q == ST_M2 || state_q == ST_M4) ? D1 : D0;
        chk_addr_d  = a_q;
        chk_elem_d  = state_q[2:0];

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_d     = ST_M0;
                    a_d         = '0;
                    en_d        = 1'b1;
                    we_d        = 1'b1;
                    di_d        = D0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                    fail_elem_d = '0;
                end
            end
            ST_M0: begin
                en_d = 1'b1;
                if (last) begin
                    state_d = ST_M1;
                    a_d     = '0;
                    wr_ph_d = 1'b0;
                end else begin
                    a_d  = a_q + A_ONE;
                    we_d = 1'b1;
                    di_d = D0;
                end
            end
            ST_M1, ST_M2, ST_M3, ST_M4: begin
                en_d = 1'b1;
                if (!wr_ph_q) begin
                    chk_d   = 1'b1;
                    we_d    = 1'b1;
                    wr_ph_d = 1'b1;
                    di_d    = (state_q == ST_M1 || state_q == ST_M3) ? D1 : D0;
                end else begin
                    wr_ph_d = 1'b0;
                    if (last) begin
                        state_d = state_q + 4'd1;
                        a_d     = (state_q == ST_M2 || state_q == ST_M3) ? A_MAX : '0;
                    end else begin
                        a_d = desc ? (a_q - A_ONE) : (a_q + A_ONE);
                    end
                end
            end
            ST_M5: begin
                chk_d = 1'b1;
                if (last) begin
                    state_d = ST_DRAIN;
                end else begin
                    en_d = 1'b1;
                    a_d  = a_q + A_ONE;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // First miscompare aborts; a write already on the bus still completes
        if (mis) begin
            state_d     = ST_DONE;
            wr_ph_d     = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            en_d        = 1'b0;
            we_d        = 1'b0;
            chk_d       = 1'b0;
            fail_d      = 1'b1;
            fail_addr_d = chk_addr_q;
            fail_data_d = RAM_Do;
            fail_elem_d = chk_elem_q;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= ST_IDLE;
            wr_ph_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            fail_elem_q <= '0;
            en_q        <= 1'b0;
            we_q        <= 1'b0;
            a_q         <= '0;
            di_q        <= '0;
            chk_q       <= 1'b0;
            chk_exp_q   <= '0;
            chk_addr_q  <= '0;
            chk_elem_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ph_q     <= wr_ph_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            fail_elem_q <= fail_elem_d;
            en_q        <= en_d;
            we_q        <= we_d;
            a_q         <= a_d;
            di_q        <= di_d;
            chk_q       <= chk_d;
            chk_exp_q   <= chk_exp_d;
            chk_addr_q  <= chk_addr_d;
            chk_elem_q  <= chk_elem_d;
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign FAIL      = fail_q;
    assign FAIL_ADDR = fail_addr_q;
    assign FAIL_DATA = fail_data_q;
    assign FAIL_ELEM = fail_elem_q;
    assign RAM_EN    = en_q;
    assign RAM_WE    = {BW{we_q}};
    assign RAM_A     = a_q;
    assign RAM_Di    = di_q;

endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: 16x32 one-cycle-read RAM model with optional
// stuck-at and decoder-alias faults, directed runs with hand-computed cycle numbers.
module tb_ram_march_bist;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        START = 1'b0;
    logic        BUSY, DONE, FAIL;
    logic [3:0]  FAIL_ADDR;
    logic [31:0] FAIL_DATA;
    logic [2:0]  FAIL_ELEM;
    logic        RAM_EN;
    logic [3:0]  RAM_WE;
    logic [3:0]  RAM_A;
    logic [31:0] RAM_Di;
    logic [31:0] RAM_Do;

    ram_march_bist #(.AW(4), .DW(32), .DBG(32'h0)) dut (
        .CLK(CLK), .RSTn(RSTn), .START(START),
        .BUSY(BUSY), .DONE(DONE), .FAIL(FAIL),
        .FAIL_ADDR(FAIL_ADDR), .FAIL_DATA(FAIL_DATA), .FAIL_ELEM(FAIL_ELEM),
        .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_A(RAM_A),
        .RAM_Di(RAM_Di), .RAM_Do(RAM_Do)
    );

    always #5 CLK = ~CLK;

    // fault: 0 none, 1 bit5 of addr 9 stuck-at-0, 2 addresses 4 and 12 share one word
    logic [31:0] mem [16];
    int          fault = 0;

    always @(posedge CLK) begin
        if (RAM_EN) begin
            if (RAM_WE == 4'hF) begin
                if (fault == 1 && RAM_A == 4'd9)
                    mem[RAM_A] <= RAM_Di & ~32'h20;
                else if (fault == 2 && (RAM_A == 4'd4 || RAM_A == 4'd12)) begin
                    mem[4]  <= RAM_Di;
                    mem[12] <= RAM_Di;
                end else
                    mem[RAM_A] <= RAM_Di;
            end else begin
                RAM_Do <= mem[RAM_A];
            end
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [3:0]  tr_a  [256];
    logic        tr_en [256];
    logic [3:0]  tr_we [256];
    logic [31:0] tr_di [256];
    logic [31:0] tr_do [256];
    logic        fail1, done1;
    int          busy_n, done_cyc;

    // Cycle c = c-th cycle after the edge that samples START; sampled at negedge
    task automatic run(input int mid_start, input int rst_at);
        busy_n   = 0;
        done_cyc = 0;
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        for (int c = 1; c < 400; c++) begin
            if (c < 256) begin
                tr_a[c]  = RAM_A;
                tr_en[c] = RAM_EN;
                tr_we[c] = RAM_WE;
                tr_di[c] = RAM_Di;
                tr_do[c] = RAM_Do;
            end
            if (c == 1) begin
                fail1 = FAIL;
                done1 = DONE;
            end
            if (BUSY) busy_n++;
            START = (c == mid_start);
            if (c == rst_at) begin
                START = 1'b0;
                RSTn  = 1'b0;
                #1;
                return;
            end
            if (DONE) begin
                done_cyc = c;
                break;
            end
            @(negedge CLK);
        end
        START = 1'b0;
        check("done_seen", done_cyc != 0, 1);
    endtask

    task automatic check_clean_run(input string tag);
        int nz;
        nz = 0;
        for (int i = 0; i < 16; i++)
            if (mem[i] !== 32'h0) nz++;
        check({tag, "_busy"}, busy_n, 161);
        check({tag, "_donecyc"}, done_cyc, 162);
        check({tag, "_done"}, DONE, 1);
        check({tag, "_fail"}, FAIL, 0);
        check({tag, "_en"}, RAM_EN, 0);
        check({tag, "_mem"}, nz, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        RAM_Do = 32'h0;

        repeat (3) @(negedge CLK);
        check("rst_ctl", {BUSY, DONE, FAIL, FAIL_ADDR, FAIL_ELEM, RAM_EN, RAM_WE, RAM_A}, 0);
        check("rst_data", {FAIL_DATA, RAM_Di}, 0);
        RSTn = 1'b1;
        repeat (2) @(negedge CLK);

        // fault-free run with a stray START in M1
        run(20, 0);
        check_clean_run("clean");
        check("tr_first_a", tr_a[1], 0);
        check("tr_first_en", tr_en[1], 1);
        check("tr_first_we", tr_we[1], 4'hF);
        check("tr_first_di", tr_di[1], 0);
        check("tr_m3_a", tr_a[81], 15);
        check("tr_m3_we", {tr_en[81], tr_we[81]}, 5'b1_0000);
        check("tr_m3_do", tr_do[82], 0);
        check("tr_m1r_a", {tr_en[23], tr_we[23], tr_a[23]}, 9'b1_0000_0011);
        check("tr_m1w_a", {tr_en[24], tr_we[24], tr_a[24]}, 9'b1_1111_0011);
        check("tr_m1w_di", tr_di[24], 32'hFFFF_FFFF);
        @(negedge CLK);
        check("done_hold", {DONE, BUSY, RAM_EN}, 3'b100);

        // stuck-at-0 bit 5 of address 9
        fault = 1;
        run(0, 0);
        check("sa_fail", FAIL, 1);
        check("sa_addr", FAIL_ADDR, 9);
        check("sa_elem", FAIL_ELEM, 2);
        check("sa_data", FAIL_DATA, 32'hFFFF_FFDF);
        check("sa_lat", (done_cyc >= 69 && done_cyc <= 70), 1);
        check("sa_en", {BUSY, RAM_EN}, 0);

        // decoder alias between 4 and 12
        fault = 2;
        run(0, 0);
        check("al_fail", FAIL, 1);
        check("al_elem", (FAIL_ELEM == 3'd1 || FAIL_ELEM == 3'd2), 1);
        check("al_addr", (FAIL_ADDR == 4'd4 || FAIL_ADDR == 4'd12), 1);

        // restart from DONE after a fail
        fault = 0;
        run(0, 0);
        check("rs_c1", {fail1, done1}, 0);
        check_clean_run("restart");

        // reset in M2 (cycle 60), then a clean run
        run(0, 60);
        check("mid_rst_ctl", {BUSY, DONE, FAIL, FAIL_ADDR, FAIL_ELEM, RAM_EN, RAM_WE, RAM_A}, 0);
        check("mid_rst_data", {FAIL_DATA, RAM_Di}, 0);
        @(negedge CLK);
        check("mid_rst_en", RAM_EN, 0);
        RSTn = 1'b1;
        repeat (2) @(negedge CLK);
        run(0, 0);
        check_clean_run("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
